// File: rtl/ripple_count_checker.sv
// Observes an asynchronous 4-bit ripple counter and emits a clean count, step strobes and a sticky error flag.
// Latency: outputs update SETTLE+3 CLK edges after a new stable Q is first sampled; no backpressure.
// Optional ERR_COUNT_EN adds a saturating ERR_CNT output counting mismatching steps.
module ripple_count_checker #(
    parameter int SETTLE = 4,
    parameter int STEP_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Q0,
    input  logic              Q1,
    input  logic              Q2,
    input  logic              Q3,
    output logic [3:0]        VALUE,
    output logic              VALID,
    output logic              WRAP,
    output logic              ERR,
    output logic [STEP_W-1:0] STEP_CNT,
`ifdef ERR_COUNT_EN
    output logic [STEP_W-1:0] ERR_CNT,
`endif
    output logic              LOCKED
);

    typedef enum logic {
        ST_ACQUIRE = 1'b0,
        ST_LOCKED  = 1'b1
    } state_t;

    localparam logic [3:0] STAB_MAX = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] q_in;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] cand;
    logic [3:0] stab;
    logic       accept;

    assign q_in = {Q3, Q2, Q1, Q0};

    // In LOCKED the held value is never re-accepted, so a glitch that returns to VALUE is invisible.
    always_comb begin
        accept = 1'b0;
        if ((sync2 == cand) && (stab == STAB_MAX)) begin
            accept = (state == ST_ACQUIRE) || (cand != VALUE);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_ACQUIRE;
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            stab     <= '0;
            VALUE    <= '0;
            VALID    <= 1'b0;
            WRAP     <= 1'b0;
            ERR      <= 1'b0;
            STEP_CNT <= '0;
            LOCKED   <= 1'b0;
`ifdef ERR_COUNT_EN
            ERR_CNT  <= '0;
`endif
        end else begin
            sync1 <= q_in;
            sync2 <= sync1;
            VALID <= 1'b0;
            WRAP  <= 1'b0;

            if (sync2 != cand) begin
                cand <= sync2;
                stab <= '0;
            end else if (stab < STAB_MAX) begin
                stab <= stab + 4'd1;
            end

            if (accept) begin
                VALUE <= cand;
                VALID <= 1'b1;
                case (state)
                    ST_ACQUIRE: begin
                        state  <= ST_LOCKED;
                        LOCKED <= 1'b1;
                    end
                    ST_LOCKED: begin
                        if (cand == VALUE + 4'd1) begin
                            if (STEP_CNT != {STEP_W{1'b1}}) begin
                                STEP_CNT <= STEP_CNT + STEP_W'(1);
                            end
                            WRAP <= (VALUE == 4'hF);
                        end else begin
                            // Mismatch: flag it and take the new value as the reference.
                            ERR <= 1'b1;
`ifdef ERR_COUNT_EN
                            if (ERR_CNT != {STEP_W{1'b1}}) begin
                                ERR_CNT <= ERR_CNT + STEP_W'(1);
                            end
`endif
                        end
                    end
                    default: state <= ST_ACQUIRE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ripple_count_checker.sv
// Bench for ripple_count_checker: vector table plus scoreboard of expected accepts, two instances (STEP_W=8 and 2).
module tb_ripple_count_checker;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] q   = 4'd0;

    logic [3:0] value1, value2;
    logic       valid1, valid2, wrap1, wrap2, err1, err2, locked1, locked2;
    logic [7:0] step1;
    logic [1:0] step2;
`ifdef ERR_COUNT_EN
    logic [7:0] errcnt1;
    logic [1:0] errcnt2;
`endif

    always #5 CLK = ~CLK;

    ripple_count_checker #(.SETTLE(4), .STEP_W(8)) dut (
        .CLK(CLK), .RST(RST), .Q0(q[0]), .Q1(q[1]), .Q2(q[2]), .Q3(q[3]),
        .VALUE(value1), .VALID(valid1), .WRAP(wrap1), .ERR(err1), .STEP_CNT(step1),
`ifdef ERR_COUNT_EN
        .ERR_CNT(errcnt1),
`endif
        .LOCKED(locked1)
    );

    ripple_count_checker #(.SETTLE(4), .STEP_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .Q0(q[0]), .Q1(q[1]), .Q2(q[2]), .Q3(q[3]),
        .VALUE(value2), .VALID(valid2), .WRAP(wrap2), .ERR(err2), .STEP_CNT(step2),
`ifdef ERR_COUNT_EN
        .ERR_CNT(errcnt2),
`endif
        .LOCKED(locked2)
    );

    typedef struct {
        logic [3:0] value;
        logic       wrap;
        logic       err;
        logic [7:0] step;
        logic [7:0] errcnt;
    } exp_t;

    typedef struct {
        logic [3:0] q;
        int         hold;
        bit         acc;
        bit         mark;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_wrap   = 0;

    logic [3:0] m_value;
    bit         m_locked;
    logic       m_err;
    int         m_step;
    int         m_errcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_value  = 4'd0;
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_step   = 0;
        m_errcnt = 0;
    endtask

    // Step-level reference: first accept only locks; later accepts are judged against +1 mod 16.
    task automatic model_accept(input logic [3:0] nv);
        exp_t e;
        e.wrap = 1'b0;
        if (m_locked) begin
            if (nv == 4'(m_value + 4'd1)) begin
                if (m_step < 255) m_step++;
                e.wrap = (m_value == 4'd15);
            end else begin
                m_err = 1'b1;
                if (m_errcnt < 255) m_errcnt++;
            end
        end
        m_locked = 1'b1;
        m_value  = nv;
        e.value  = nv;
        e.err    = m_err;
        e.step   = 8'(m_step);
        e.errcnt = 8'(m_errcnt);
        sb.push_back(e);
    endtask

    // Scoreboard side: every VALID pulse must match the oldest expected accept.
    always @(negedge CLK) begin
        if (!RST) begin
            if (wrap1 && !valid1) begin
                n_checks++;
                n_fail++;
                $display("FAIL wrap_without_valid: got 1 expected 0 at %0t", $time);
            end
            if (valid1) begin
                n_valid++;
                if (wrap1) n_wrap++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got VALUE=%0d expected no pulse at %0t", value1, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_value", 32'(value1), 32'(e.value));
                    check("sb_wrap", 32'(wrap1), 32'(e.wrap));
                    check("sb_err", 32'(err1), 32'(e.err));
                    check("sb_step_cnt", 32'(step1), 32'(e.step));
                    check("sb_locked", 32'(locked1), 32'd1);
`ifdef ERR_COUNT_EN
                    check("sb_err_cnt", 32'(errcnt1), 32'(e.errcnt));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        for (int i = 2; i <= 15; i++) tbl.push_back('{4'(i), 10, 1'b1, 1'b0});
        tbl.push_back('{4'd0, 10, 1'b1, 1'b1});
        tbl.push_back('{4'd1, 10, 1'b1, 1'b0});
        tbl.push_back('{4'd2, 10, 1'b1, 1'b0});
        tbl.push_back('{4'd3, 10, 1'b1, 1'b0});
        tbl.push_back('{4'd5, 10, 1'b1, 1'b0});
        tbl.push_back('{4'd6, 10, 1'b1, 1'b0});
        tbl.push_back('{4'd7, 10, 1'b1, 1'b0});
        tbl.push_back('{4'd6, 2, 1'b0, 1'b0});
        tbl.push_back('{4'd8, 10, 1'b1, 1'b0});
        tbl.push_back('{4'd3, 2, 1'b0, 1'b0});
        tbl.push_back('{4'd8, 10, 1'b0, 1'b0});
        tbl.push_back('{4'd9, 10, 1'b1, 1'b0});

        repeat (3) @(negedge CLK);
        check("rst_value", 32'(value1), 32'd0);
        check("rst_valid", 32'(valid1), 32'd0);
        check("rst_wrap", 32'(wrap1), 32'd0);
        check("rst_err", 32'(err1), 32'd0);
        check("rst_step_cnt", 32'(step1), 32'd0);
        check("rst_locked", 32'(locked1), 32'd0);

        // Q held at 0: first accept lands on edge SETTLE after release.
        RST = 1'b0;
        model_accept(4'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            check("lock_valid_timing", 32'(valid1), 32'(k == 4));
            check("lock_locked_timing", 32'(locked1), 32'(k == 4));
        end
        check("lock_err", 32'(err1), 32'd0);
        repeat (6) @(negedge CLK);

        // First step: VALID exactly at edge SETTLE+3 after the change.
        n_valid = 0;
        n_wrap  = 0;
        q = 4'd1;
        model_accept(4'd1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            check("step_valid_timing", 32'(valid1), 32'(k == 7));
        end
        repeat (3) @(negedge CLK);

        for (int i = 0; i < tbl.size(); i++) begin
            q = tbl[i].q;
            if (tbl[i].acc) model_accept(tbl[i].q);
            repeat (tbl[i].hold) @(negedge CLK);
            if (tbl[i].acc) begin
                check("value_after_row", 32'(value1), 32'(tbl[i].q));
                check("sat_step_cnt", 32'(step2), (m_step > 3) ? 32'd3 : 32'(m_step));
            end
            if (tbl[i].mark) begin
                check("clean_step_cnt", 32'(step1), 32'd16);
                check("clean_valid_pulses", 32'(n_valid), 32'd16);
                check("clean_wrap_pulses", 32'(n_wrap), 32'd1);
                check("clean_err", 32'(err1), 32'd0);
            end
        end
        check("glitch_value", 32'(value1), 32'd9);
        check("err_sticky", 32'(err1), 32'd1);

        // Reset two cycles into settling 9 -> 10, then 10 is taken without a check.
        q = 4'd10;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("mid_rst_value", 32'(value1), 32'd0);
        check("mid_rst_err", 32'(err1), 32'd0);
        check("mid_rst_step_cnt", 32'(step1), 32'd0);
        check("mid_rst_locked", 32'(locked1), 32'd0);
        check("mid_rst_valid", 32'(valid1), 32'd0);
        RST = 1'b0;
        model_reset();
        model_accept(4'd10);
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            check("rst_reacq_valid_timing", 32'(valid1), 32'(k == 7));
        end
        check("rst_reacq_value", 32'(value1), 32'd10);
        check("rst_reacq_err", 32'(err1), 32'd0);
        check("rst_reacq_locked", 32'(locked1), 32'd1);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge CLK);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
